line_engine: RTL and testbench
==============================

# line_engine

Bresenham line rasterizer sitting downstream of the graphics command processor. It accepts a color, two endpoints and a frame base over the LE_* handshake and walks every pixel of the line in all octants. Each pixel is written to the framebuffer in DRAM as a masked two-beat write through the request controller's address and write-data FIFOs.

## Interface
- No parameters. Coordinates are fixed at 10 bits; pixels are 32 bits; the frame is 1024 pixels wide, row pitch 4096 B.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- LE_ready  out  1  high only in IDLE; commands accepted only while high
- LE_color  in  32  pixel value, captured when LE_color_valid && LE_ready
- LE_color_valid  in  1  color strobe
- LE_point  in  20  {x[9:0], y[9:0]}
- LE_point0_valid  in  1  captures LE_point as start point
- LE_point1_valid  in  1  captures LE_point as end point
- LE_trigger  in  1  start line; LE_frame captured the same cycle
- LE_frame  in  32  frame base byte address, 4 MB aligned
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_wr_en  out  1  address push
- af_addr_din  out  31  {frame[30:22], y, x[9:3], 5'b0}
- wdf_wr_en  out  1  data push
- wdf_din  out  128  {4{color}}
- wdf_mask_din  out  16  byte mask per beat; 1 = byte not written

## Operation
- States: IDLE, SETUP, WRITE0, WRITE1.
- IDLE
  - LE_ready = 1.
  - Each valid strobe loads its register.
  - point1_valid and trigger may coincide; point1 is captured that cycle.
  - On LE_trigger: go to SETUP, LE_ready drops next cycle.
- SETUP (1 cycle), from the registered points:
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = (x0<x1) ? +1 : -1; sy likewise.
  - err = dx + dy, 13-bit signed.
  - (x,y) = (x0,y0).
  - Go to WRITE0.
- WRITE0
  - When !af_full && !wdf_full: assert af_wr_en and wdf_wr_en (beat 0) in the same cycle, then go to WRITE1.
  - Otherwise hold with both enables low.
- WRITE1
  - When !wdf_full: assert wdf_wr_en (beat 1).
  - If (x,y) == (x1,y1), go to IDLE.
  - Otherwise step and go to WRITE0. Step: e2 = 2*err; if e2 >= dy then err += dy, x += sx; if e2 <= dx then err += dx, y += sy. Both updates use the pre-step err.
  - If wdf_full, hold.
- Beat data: beat 0 carries pixels x[2:0] = 0..3, beat 1 carries 4..7. Pixel k occupies bits 32k+31:32k of its beat.
- Mask for p = x[2:0]:
  - Beat p[2]: ~(16'h000F << 4*p[1:0]).
  - Other beat: 16'hFFFF.
- No clipping; any coordinate 0..1023 is written.
- point0 == point1 produces exactly one pixel.
- Strobes and trigger arriving while LE_ready = 0 are ignored.

## Timing
- Reset values:
  - State IDLE, LE_ready = 1.
  - af_wr_en = wdf_wr_en = 0, af_addr_din = 0, wdf_din = 0, wdf_mask_din = 16'hFFFF.
  - Coordinate, color and frame registers = 0.
- rst mid-line: abandon the line, next cycle IDLE with all enables low. A half-issued burst is not completed; the DRAM controller resets with us.
- Trigger at cycle T:
  - SETUP at T+1.
  - First af_wr_en at T+2, absent backpressure.
  - Throughput 2 cycles/pixel.
  - An N-pixel line returns LE_ready at T+2N+2.
- Outputs are registered from state, or combinational on state plus the full flags; no input reaches an output combinationally except through the full flags.
- Beat 1 always immediately follows beat 0 unless wdf_full intervenes; no other write is interleaved.

## Test plan
- Horizontal line, frame 0x10400000, color 0x00FF0000, (0,0)->(3,0):
  - 4 bursts, all af_addr_din 0x10400000.
  - Beat-0 masks FFF0, FF0F, F0FF, 0FFF; beat-1 masks all FFFF.
  - LE_ready returns at T+10.
- Single pixel (5,10)->(5,10):
  - One burst, addr 0x1040A000.
  - Masks FFFF then FF0F.
  - wdf_din = {4{color}}.
- Steep reverse-octant line (5,10)->(7,3): pixel order exactly (5,10), (5,9), (6,8), (6,7), (6,6), (6,5), (7,4), (7,3).
- Backpressure:
  - af_full held high for 5 cycles during WRITE0: no enables asserted, pixel sequence unchanged.
  - wdf_full high in WRITE1: beat 1 delayed, no duplicate beats.
- Trigger and strobes while busy: new color/points pulsed mid-line do not alter the line in progress or the registers used by the next line.
- rst asserted during the third pixel of an 8-pixel line: next cycle all enables low, LE_ready = 1; a fresh line afterward draws correctly.

Source files
------------

// File: rtl/line_engine.sv
// line_engine: Bresenham line rasterizer issuing masked two-beat framebuffer writes
module line_engine (
  input  logic         clk,
  input  logic         rst,
  output logic         LE_ready,
  input  logic [31:0]  LE_color,
  input  logic         LE_color_valid,
  input  logic [19:0]  LE_point,
  input  logic         LE_point0_valid,
  input  logic         LE_point1_valid,
  input  logic         LE_trigger,
  input  logic [31:0]  LE_frame,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din
);
  typedef enum logic [1:0] {IDLE, SETUP, WRITE0, WRITE1} state_t;
  state_t state_q, state_d;
  logic [31:0] color_q, color_d;
  logic [8:0] frame_q, frame_d;
  logic [9:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d, x_q, x_d, y_q, y_d;
  logic [9:0] adx, ady;
  logic signed [12:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [13:0] e2;
  logic sx_q, sx_d, sy_q, sy_d;
  logic [15:0] pix_mask;
  logic unused_frame;
  assign unused_frame = ^{LE_frame[31], LE_frame[21:0]};
  assign adx = x0_q < x1_q ? x1_q - x0_q : x0_q - x1_q;
  assign ady = y0_q < y1_q ? y1_q - y0_q : y0_q - y1_q;
  assign e2 = {err_q, 1'b0};
  // Sequencer: command capture, setup and the Bresenham step taken once beat 1 is accepted
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    frame_d = frame_q;
    x0_d = x0_q;
    y0_d = y0_q;
    x1_d = x1_q;
    y1_d = y1_q;
    x_d = x_q;
    y_d = y_q;
    dx_d = dx_q;
    dy_d = dy_q;
    err_d = err_q;
    sx_d = sx_q;
    sy_d = sy_q;
    case (state_q)
      IDLE: begin
        if (LE_color_valid) color_d = LE_color;
        if (LE_point0_valid) {x0_d, y0_d} = LE_point;
        if (LE_point1_valid) {x1_d, y1_d} = LE_point;
        if (LE_trigger) begin
          frame_d = LE_frame[30:22];
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d = {3'b0, adx};
        dy_d = -{3'b0, ady};
        sx_d = !(x0_q < x1_q);
        sy_d = !(y0_q < y1_q);
        err_d = {3'b0, adx} - {3'b0, ady};
        x_d = x0_q;
        y_d = y0_q;
        state_d = WRITE0;
      end
      WRITE0: state_d = (!af_full && !wdf_full) ? WRITE1 : WRITE0;
      WRITE1: begin
        if (!wdf_full) begin
          if (x_q == x1_q && y_q == y1_q) state_d = IDLE;
          else begin
            state_d = WRITE0;
            if (e2 >= dy_q) begin
              err_d = err_d + dy_q;
              x_d = sx_q ? x_q - 10'd1 : x_q + 10'd1;
            end
            if (e2 <= dx_q) begin
              err_d = err_d + dx_q;
              y_d = sy_q ? y_q - 10'd1 : y_q + 10'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= '0;
      frame_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      x_q <= '0;
      y_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      err_q <= '0;
      sx_q <= 1'b0;
      sy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      frame_q <= frame_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      x_q <= x_d;
      y_q <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      err_q <= err_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
    end
  end
  // Write port: enables gated only by state and full flags, data from registers
  always_comb begin
    pix_mask = ~(16'h000F << {x_q[1:0], 2'b00});
    LE_ready = state_q == IDLE;
    af_wr_en = state_q == WRITE0 && !af_full && !wdf_full;
    wdf_wr_en = af_wr_en || (state_q == WRITE1 && !wdf_full);
    af_addr_din = {frame_q, y_q, x_q[9:3], 5'b0};
    wdf_din = {4{color_q}};
    wdf_mask_din = ((state_q == WRITE0 && !x_q[2]) || (state_q == WRITE1 && x_q[2])) ? pix_mask : 16'hFFFF;
  end
endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed self-checking bench for line_engine
module tb_line_engine;
  logic clk = 0, rst = 1;
  logic LE_ready, LE_color_valid = 0, LE_point0_valid = 0, LE_point1_valid = 0, LE_trigger = 0;
  logic [31:0] LE_color = 0, LE_frame = 0;
  logic [19:0] LE_point = 0;
  logic af_full = 0, wdf_full = 0, af_wr_en, wdf_wr_en;
  logic [30:0] af_addr_din;
  logic [127:0] wdf_din;
  logic [15:0] wdf_mask_din;
  int n_cmp = 0, n_err = 0, cyc = 0, t0 = 0, af_cyc = 0;
  logic [31:0] exp_color = 0, exp_frame = 0;
  logic [9:0] st_x[8] = '{10'd5, 10'd5, 10'd6, 10'd6, 10'd6, 10'd6, 10'd7, 10'd7};
  logic [9:0] st_y[8] = '{10'd10, 10'd9, 10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3};

  line_engine dut (
    .clk(clk), .rst(rst), .LE_ready(LE_ready),
    .LE_color(LE_color), .LE_color_valid(LE_color_valid),
    .LE_point(LE_point), .LE_point0_valid(LE_point0_valid), .LE_point1_valid(LE_point1_valid),
    .LE_trigger(LE_trigger), .LE_frame(LE_frame),
    .af_full(af_full), .wdf_full(wdf_full),
    .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
    .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [31:0] col, input logic [9:0] x0, y0, x1, y1, input logic [31:0] fr);
    LE_color = col;
    LE_color_valid = 1;
    LE_point = {x0, y0};
    LE_point0_valid = 1;
    @(negedge clk);
    LE_color_valid = 0;
    LE_point0_valid = 0;
    LE_point = {x1, y1};
    LE_point1_valid = 1;
    LE_trigger = 1;
    LE_frame = fr;
    t0 = cyc;
    @(negedge clk);
    LE_point1_valid = 0;
    LE_trigger = 0;
    exp_color = col;
    exp_frame = fr;
    #1;
    chk("ready_setup", LE_ready, 0);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input int stall);
    int n = 0;
    logic [15:0] m;
    m = ~(16'h000F << (4 * x[1:0]));
    #1;
    while (!af_wr_en && n < 40) begin
      chk("stray_wdf", wdf_wr_en, 0);
      @(negedge clk);
      #1;
      n++;
    end
    af_cyc = cyc;
    chk("af_wr_en0", af_wr_en, 1);
    chk("addr", af_addr_din, {exp_frame[30:22], y, x[9:3], 5'b0});
    chk("wdf_wr_en0", wdf_wr_en, 1);
    chk("mask0", wdf_mask_din, x[2] ? 16'hFFFF : m);
    chk("wdf_din", wdf_din, {4{exp_color}});
    @(negedge clk);
    if (stall > 0) begin
      wdf_full = 1;
      #1;
      repeat (stall) begin
        chk("wdf_stall_en", {af_wr_en, wdf_wr_en}, 0);
        @(negedge clk);
        #1;
      end
      wdf_full = 0;
    end
    #1;
    chk("af_wr_en1", af_wr_en, 0);
    chk("wdf_wr_en1", wdf_wr_en, 1);
    chk("mask1", wdf_mask_din, x[2] ? m : 16'hFFFF);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (!LE_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_back", LE_ready, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", LE_ready, 1);
    chk("rst_en", {af_wr_en, wdf_wr_en}, 0);
    chk("rst_addr", af_addr_din, 0);
    chk("rst_din", wdf_din, 0);
    chk("rst_mask", wdf_mask_din, 16'hFFFF);
    rst = 0;
    @(negedge clk);
    cmd(32'h00FF0000, 10'd0, 10'd0, 10'd3, 10'd0, 32'h10400000);
    for (int i = 0; i < 4; i++) begin
      pix(10'(i), 10'd0, 0);
      if (i == 0) chk("first_af_cycle", af_cyc, t0 + 2);
    end
    chk("horiz_addr_const", af_addr_din, 31'h10400000);
    wait_ready();
    chk("horiz_ready_cycle", cyc, t0 + 10);
    cmd(32'h12345678, 10'd5, 10'd10, 10'd5, 10'd10, 32'h10400000);
    pix(10'd5, 10'd10, 0);
    wait_ready();
    chk("single_ready_cycle", cyc, t0 + 4);
    chk("single_addr_const", af_addr_din, 31'h1040A000);
    cmd(32'hCAFEF00D, 10'd5, 10'd10, 10'd7, 10'd3, 32'h20000000);
    af_full = 1;
    LE_color = 32'hDEADBEEF;
    LE_color_valid = 1;
    LE_point = {10'd100, 10'd200};
    LE_point0_valid = 1;
    LE_point1_valid = 1;
    LE_trigger = 1;
    LE_frame = 32'hFFC00000;
    @(negedge clk);
    LE_color_valid = 0;
    LE_point0_valid = 0;
    LE_point1_valid = 0;
    LE_trigger = 0;
    #1;
    repeat (5) begin
      chk("af_stall_en", {af_wr_en, wdf_wr_en}, 0);
      @(negedge clk);
      #1;
    end
    af_full = 0;
    for (int i = 0; i < 8; i++) pix(st_x[i], st_y[i], i == 3 ? 3 : 0);
    wait_ready();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("no_busy_trigger", {LE_ready, af_wr_en, wdf_wr_en}, 3'b100);
    end
    LE_trigger = 1;
    LE_frame = 32'h20000000;
    @(negedge clk);
    LE_trigger = 0;
    for (int i = 0; i < 2; i++) pix(st_x[i], st_y[i], 0);
    begin
      int n = 0;
      #1;
      while (!af_wr_en && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    chk("third_addr", af_addr_din, {9'h080, 10'd8, 7'd0, 5'b0});
    rst = 1;
    @(negedge clk);
    #1;
    chk("midrst_ready", LE_ready, 1);
    chk("midrst_en", {af_wr_en, wdf_wr_en}, 0);
    rst = 0;
    @(negedge clk);
    #1;
    chk("postrst_regs", {af_addr_din, wdf_din}, 0);
    cmd(32'hA5A5A5A5, 10'd1020, 10'd1, 10'd1023, 10'd4, 32'h7FC00000);
    for (int i = 0; i < 4; i++) pix(10'(1020 + i), 10'(1 + i), 0);
    wait_ready();
    chk("edge_addr_const", af_addr_din, {9'h1FF, 10'd4, 7'h7F, 5'b0});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
